selftrigger_frame_builder: RTL and testbench

- Consumer end of the self-trigger path: takes the filter's 16-bit sample stream `y` and its `trigger` pulse, and turns each trigger into a framed waveform record.
- Each frame carries a header, pre-trigger samples and post-trigger samples, sent on a valid/ready stream towards readout.
- Sits per channel, directly downstream of the self-trigger filter, on the same clock.

---
 rtl/selftrigger_frame_builder_if.sv | 22 ++
 rtl/selftrigger_frame_builder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_selftrigger_frame_builder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/selftrigger_frame_builder_if.sv
// Output stream bundle of the self-trigger frame builder.
// Carries one 16-bit word per accepted valid/ready beat, with an end-of-frame flag.
interface selftrigger_frame_builder_if;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/selftrigger_frame_builder.sv
// Self-trigger frame builder: turns filter trigger edges into framed sample records.
// Define SELFTRIG_FRAME_CHECKSUM_EN to append a 16-bit sample-sum trailer word.
module selftrigger_frame_builder #(
    parameter int unsigned PRE_SAMPLES = 64,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter logic [7:0]  HDR_MARK    = 8'hA5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic signed [15:0]          x,
    input  logic                        trigger,
    input  logic [63:0]                 timestamp,
    input  logic [7:0]                  channel_id,
    selftrigger_frame_builder_if.master m,
    output logic                        busy,
    output logic [15:0]                 frames_dropped
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FRAME_LEN);
    localparam logic [AW:0]   LEN_F    = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0]   DEPTH_F  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        CAP_IDLE,
        CAP_RUN
    } cap_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_HDR,
        OUT_DATA
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
        , OUT_TRL
`endif
    } out_e;

    logic [15:0]   dl_q [PRE_SAMPLES];
    logic [15:0]   dl_out;
    logic          trig_q;
    logic          trig_edge;

    cap_e          cap_q, cap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   drop_q, drop_d;
    logic          hdr_full_q;
    logic [7:0]    hdr_ch_q;
    logic [63:0]   hdr_ts_q;
    logic          hdr_load;
    logic          hdr_release;

    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_cnt_q;
    logic [AW:0]   fifo_free;
    logic          fifo_empty;
    logic          fifo_we;
    logic          fifo_wlast;
    logic          fifo_re;
    logic [16:0]   fifo_head;

    out_e          out_q, out_d;
    logic [2:0]    hw_q, hw_d;
    logic [15:0]   hdr_word;
    logic [15:0]   m_data_w;
    logic          m_valid_w;
    logic          m_last_w;

`ifdef SELFTRIG_FRAME_CHECKSUM_EN
    logic [15:0]   sum_q, sum_d;
`endif

    // Delay line: slot 0 takes the newest strobe, the last slot is x delayed by PRE_SAMPLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PRE_SAMPLES; i++) dl_q[i] <= '0;
        end else if (enable) begin
            dl_q[0] <= x;
            for (int i = 1; i < PRE_SAMPLES; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign dl_out = dl_q[PRE_SAMPLES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    trig_q <= 1'b0;
        else if (enable) trig_q <= trigger;
    end

    assign trig_edge = enable & trigger & ~trig_q;
    assign fifo_free = DEPTH_F - fifo_cnt_q;

    // The admitting strobe already writes the oldest pre-trigger sample.
    always_comb begin
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        hdr_load   = 1'b0;
        fifo_we    = 1'b0;
        fifo_wlast = 1'b0;
        unique case (cap_q)
            CAP_IDLE: begin
                if (trig_edge) begin
                    if (!hdr_full_q && fifo_free >= LEN_F) begin
                        cap_d    = CAP_RUN;
                        hdr_load = 1'b1;
                        fifo_we  = 1'b1;
                        cnt_d    = CW'(1);
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            CAP_RUN: begin
                if (enable) begin
                    fifo_we    = 1'b1;
                    fifo_wlast = (cnt_q == LAST_CNT);
                    cnt_d      = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) cap_d = CAP_IDLE;
                end
            end
            default: cap_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q      <= CAP_IDLE;
            cnt_q      <= '0;
            drop_q     <= '0;
            hdr_full_q <= 1'b0;
            hdr_ch_q   <= '0;
            hdr_ts_q   <= '0;
        end else begin
            cap_q  <= cap_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            if (hdr_load) begin
                hdr_full_q <= 1'b1;
                hdr_ch_q   <= channel_id;
                hdr_ts_q   <= timestamp;
            end else if (hdr_release) begin
                hdr_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_we) mem_q[wr_ptr_q] <= {fifo_wlast, dl_out};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_we) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (fifo_re) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (fifo_we && !fifo_re)      fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
            else if (!fifo_we && fifo_re) fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
        end
    end

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];

    always_comb begin
        unique case (hw_q)
            3'd0:    hdr_word = {HDR_MARK, hdr_ch_q};
            3'd1:    hdr_word = hdr_ts_q[63:48];
            3'd2:    hdr_word = hdr_ts_q[47:32];
            3'd3:    hdr_word = hdr_ts_q[31:16];
            default: hdr_word = hdr_ts_q[15:0];
        endcase
    end

    always_comb begin
        out_d       = out_q;
        hw_d        = hw_q;
        fifo_re     = 1'b0;
        hdr_release = 1'b0;
        m_data_w    = '0;
        m_valid_w   = 1'b0;
        m_last_w    = 1'b0;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        unique case (out_q)
            OUT_IDLE: begin
                if (hdr_full_q) begin
                    out_d = OUT_HDR;
                    hw_d  = 3'd0;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
                    sum_d = '0;
`endif
                end
            end
            OUT_HDR: begin
                m_valid_w = 1'b1;
                m_data_w  = hdr_word;
                if (m.m_ready) begin
                    if (hw_q == 3'd4) begin
                        hdr_release = 1'b1;
                        out_d       = OUT_DATA;
                    end else begin
                        hw_d = hw_q + 3'd1;
                    end
                end
            end
            OUT_DATA: begin
                m_valid_w = ~fifo_empty;
                m_data_w  = fifo_head[15:0];
`ifndef SELFTRIG_FRAME_CHECKSUM_EN
                m_last_w  = ~fifo_empty & fifo_head[16];
`endif
                if (!fifo_empty && m.m_ready) begin
                    fifo_re = 1'b1;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
                    sum_d = sum_q + fifo_head[15:0];
                    if (fifo_head[16]) out_d = OUT_TRL;
`else
                    if (fifo_head[16]) out_d = OUT_IDLE;
`endif
                end
            end
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
            OUT_TRL: begin
                m_valid_w = 1'b1;
                m_data_w  = sum_q;
                m_last_w  = 1'b1;
                if (m.m_ready) out_d = OUT_IDLE;
            end
`endif
            default: out_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= OUT_IDLE;
            hw_q  <= '0;
        end else begin
            out_q <= out_d;
            hw_q  <= hw_d;
        end
    end

`ifdef SELFTRIG_FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end
`endif

    assign m.m_data       = m_data_w;
    assign m.m_valid      = m_valid_w;
    assign m.m_last       = m_last_w;
    assign busy           = (cap_q == CAP_RUN);
    assign frames_dropped = drop_q;

endmodule

// File: tb/tb_selftrigger_frame_builder.sv
// Bench for selftrigger_frame_builder: directed scenarios plus random traffic
// scored against a frame-level model of the stream.
module tb_selftrigger_frame_builder;

    localparam int PRE   = 4;
    localparam int LEN   = 8;
    localparam int DEPTH = 16;
    localparam logic [7:0] MARK = 8'hA5;
`ifdef SELFTRIG_FRAME_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        bit          last;
        int          kind;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] x = '0;
    logic        trigger = 1'b0;
    logic [63:0] timestamp = '0;
    logic [7:0]  channel_id = 8'd3;
    logic        busy;
    logic [15:0] frames_dropped;

    selftrigger_frame_builder_if sif ();

    selftrigger_frame_builder #(
        .PRE_SAMPLES(PRE),
        .FRAME_LEN  (LEN),
        .FIFO_DEPTH (DEPTH),
        .HDR_MARK   (MARK)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .x             (x),
        .trigger       (trigger),
        .timestamp     (timestamp),
        .channel_id    (channel_id),
        .m             (sif.master),
        .busy          (busy),
        .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] hist[$];
    word_t       expq[$];
    bit          trig_prev;
    int          cap_rem, hdr_left, occ;
    logic [15:0] drop_exp, sum_m;
    bit          pv, pl;
    logic [15:0] pd;
    logic [15:0] seen[$];
    int          last_idx, frames;
    bit          last_valid;
    logic [63:0] ts_v = '0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        expq.delete();
        trig_prev = 1'b0;
        cap_rem   = 0;
        hdr_left  = 0;
        occ       = 0;
        drop_exp  = '0;
        sum_m     = '0;
        pv        = 1'b0;
    endtask

    task automatic put_sample(logic [15:0] d);
        word_t w;
        cap_rem--;
        occ++;
        sum_m  = sum_m + d;
        w.d    = d;
        w.last = (cap_rem == 0) && !CK;
        w.kind = 1;
        expq.push_back(w);
        if (cap_rem == 0 && CK) begin
            w.d = sum_m; w.last = 1'b1; w.kind = 2;
            expq.push_back(w);
        end
    endtask

    task automatic step(bit en, logic [15:0] xv, bit trg, bit rdy);
        bit          slot_free, room, edge_, acc;
        logic [15:0] d;
        logic [63:0] ts;
        word_t       w;
        @(negedge clk);
        enable = en; x = xv; trigger = trg; sif.m_ready = rdy;
        timestamp = ts_v;
        #1;
        check_eq("busy", busy, cap_rem > 0);
        check_eq("dropped", frames_dropped, drop_exp);
        if (pv) begin
            check_eq("stall_valid", sif.m_valid, 1'b1);
            check_eq("stall_data", sif.m_data, pd);
            check_eq("stall_last", sif.m_last, pl);
        end
        slot_free  = (hdr_left == 0);
        room       = (DEPTH - occ) >= LEN;
        acc        = sif.m_valid & rdy;
        last_valid = sif.m_valid;
        if (acc) begin
            if (expq.size() == 0) begin
                check_eq("spurious_word", sif.m_valid, 1'b0);
            end else begin
                w = expq.pop_front();
                check_eq("data", sif.m_data, w.d);
                check_eq("last", sif.m_last, w.last);
                if (w.kind == 0) hdr_left--;
                else if (w.kind == 1) occ--;
            end
            seen.push_back(sif.m_data);
            if (sif.m_last) begin
                frames++;
                last_idx = seen.size() - 1;
            end
        end
        pv = sif.m_valid & ~rdy;
        pd = sif.m_data;
        pl = sif.m_last;
        if (en) begin
            edge_ = trg & ~trig_prev;
            trig_prev = trg;
            d = 16'h0;
            if (hist.size() == PRE) d = hist.pop_front();
            hist.push_back(xv);
            if (cap_rem > 0) begin
                put_sample(d);
            end else if (edge_) begin
                if (slot_free && room) begin
                    ts = timestamp;
                    w.kind = 0; w.last = 1'b0;
                    w.d = {MARK, channel_id}; expq.push_back(w);
                    w.d = ts[63:48]; expq.push_back(w);
                    w.d = ts[47:32]; expq.push_back(w);
                    w.d = ts[31:16]; expq.push_back(w);
                    w.d = ts[15:0];  expq.push_back(w);
                    hdr_left = 5;
                    cap_rem  = LEN;
                    sum_m    = '0;
                    put_sample(d);
                end else if (drop_exp != 16'hFFFF) begin
                    drop_exp++;
                end
            end
        end
        ts_v++;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((expq.size() != 0 || cap_rem != 0) && n < budget) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b1);
            n++;
        end
        check_eq("drain_left", expq.size(), 0);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        check_eq("idle_after_drain", sif.m_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        enable = 1'b0; trigger = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_valid", sif.m_valid, 1'b0);
        check_eq("rst_last", sif.m_last, 1'b0);
        check_eq("rst_data", sif.m_data, 16'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_dropped", frames_dropped, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic new_test();
        seen.delete();
        frames   = 0;
        last_idx = -1;
    endtask

    always @(posedge clk) begin
        if (reset_n && dut.fifo_we)
            check_eq("fifo_overflow", dut.fifo_cnt_q >= DEPTH, 1'b0);
    end

    initial begin
        int trig_i, fv;
        bit lvl;
        sif.m_ready = 1'b0;
        model_clear();
        new_test();
        repeat (2) @(negedge clk);
        check_eq("init_valid", sif.m_valid, 1'b0);
        check_eq("init_data", sif.m_data, 16'h0);
        check_eq("init_busy", busy, 1'b0);
        reset_n = 1'b1;

        // Basic ramp frame
        new_test();
        ts_v   = 64'h1234 - 64'd9;
        trig_i = 10;
        fv     = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 16'(i), (i >= 10 && i < 13), 1'b1);
            if (fv < 0 && last_valid) fv = i;
        end
        check_eq("hdr_latency_ok", (fv - trig_i >= 1) && (fv - trig_i <= 2), 1'b1);
        drain(100);
        check_eq("basic_len", seen.size(), 5 + LEN + CK);
        check_eq("basic_w0", seen[0], 16'hA503);
        check_eq("basic_w1", seen[1], 16'h0000);
        check_eq("basic_w4", seen[4], 16'h1234);
        check_eq("basic_s0", seen[5], 16'd6);
        check_eq("basic_s4", seen[9], 16'd10);
        check_eq("basic_s7", seen[12], 16'd13);
        check_eq("basic_last_at", last_idx, 12 + CK);
        if (CK) check_eq("basic_trailer", seen[13], 16'h004C);
        check_eq("basic_dropped", frames_dropped, 16'h0);

        // Trigger level held for 100 strobes
        new_test();
        for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'b1, 1'b1);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        drain(100);
        step(1'b1, 16'($urandom), 1'b1, 1'b1);
        step(1'b1, 16'($urandom), 1'b1, 1'b1);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        drain(100);
        check_eq("held_frames", frames, 2);

        // Backpressure during capture, second trigger refused
        new_test();
        step(1'b1, 16'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 1'b1, 1'b0);
        step(1'b1, 16'($urandom), 1'b0, 1'b0);
        check_eq("bp_dropped", frames_dropped, 16'd1);
        check_eq("bp_stalled", sif.m_valid, 1'b1);
        drain(100);
        check_eq("bp_frames", frames, 1);
        check_eq("bp_len", seen.size(), 5 + LEN + CK);

        // Early trigger right after reset
        pulse_reset();
        new_test();
        step(1'b1, 16'h0111, 1'b0, 1'b1);
        step(1'b1, 16'h0222, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b1);
        drain(100);
        check_eq("early_z0", seen[5], 16'h0);
        check_eq("early_z2", seen[7], 16'h0);
        check_eq("early_s0", seen[8], 16'h0111);
        check_eq("early_trg", seen[9], 16'h0222);

        // Reset pulse while samples drain
        new_test();
        step(1'b1, 16'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
        check_eq("mid_in_data", sif.m_valid, 1'b1);
        pulse_reset();
        new_test();
        step(1'b1, 16'($urandom), 1'b1, 1'b1);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        drain(100);
        check_eq("post_rst_len", seen.size(), 5 + LEN + CK);
        check_eq("post_rst_frames", frames, 1);

        // Random traffic
        new_test();
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) lvl = ~lvl;
            step($urandom_range(0, 9) < 7, 16'($urandom), lvl,
                 $urandom_range(0, 9) < 6);
        end
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
